// File: rtl/codec_model.sv
// codec_model
//   Synthesizable CODEC-side endpoint of an I2S serial link. It receives
//   SCLK/LRCLK/SDin from the link master, deserialises the left/right DAC words,
//   and serialises the supplied left/right ADC words onto SDout.
//
// Ports
//   clk      system clock; SCLK/LRCLK are oversampled in this domain
//   rst      synchronous active-high reset
//   RSTn     CODEC reset from the master, active low (synchronized here)
//   SCLK     serial bit clock
//   LRCLK    frame clock: low = left slot, high = right slot
//   SDin     serial data from the master (DAC path)
//   SDout    serial data to the master (ADC path)
//   lft_tx   left word to transmit, latched at left-slot entry
//   rht_tx   right word to transmit, latched at left-slot entry
//   tx_ack   1-clk pulse: lft_tx/rht_tx latched for the next frame
//   lft_rx   last complete received left word
//   rht_rx   last complete received right word
//   rx_vld   1-clk pulse: lft_rx/rht_rx updated
//   frm_err  1-clk pulse: a channel slot ended before DATA_W bits arrived
module codec_model #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RSTn,
   input  logic              SCLK,
   input  logic              LRCLK,
   input  logic              SDin,
   output logic              SDout,
   input  logic [DATA_W-1:0] lft_tx,
   input  logic [DATA_W-1:0] rht_tx,
   output logic              tx_ack,
   output logic [DATA_W-1:0] lft_rx,
   output logic [DATA_W-1:0] rht_rx,
   output logic              rx_vld,
   output logic              frm_err
);

   localparam int CW = $clog2(DATA_W + 2);
   // Rise count at which the LSB has been sampled; the counter saturates here.
   localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] rstn_sync_q;
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] lrck_sync_q;
   logic [SYNC_STAGES-1:0] sdin_sync_q;
   logic                   sclk_hist_q;
   logic                   lrck_hist_q;

   logic [CW-1:0]     cnt_q, cnt_d;       // SCLK rises since slot start
   logic [CW-1:0]     fcnt_q, fcnt_d;     // SCLK falls since slot start
   logic [DATA_W-1:0] lsr_q, lsr_d;       // left receive shift register
   logic [DATA_W-1:0] rsr_q, rsr_d;       // right receive shift register
   logic [DATA_W-1:0] lsh_q, lsh_d;       // left transmit shadow
   logic [DATA_W-1:0] rsh_q, rsh_d;       // right transmit shadow
   logic              lok_q, lok_d;       // left slot of this frame was complete
   logic              sdout_q, sdout_d;
   logic              tx_ack_q, tx_ack_d;
   logic              rx_vld_q, rx_vld_d;
   logic              frm_err_q, frm_err_d;
   logic [DATA_W-1:0] lft_rx_q, lft_rx_d;
   logic [DATA_W-1:0] rht_rx_q, rht_rx_d;

   logic soft_rst_s;
   logic sclk_s, lrck_s, sdin_s;
   logic sclk_rise_s, sclk_fall_s, lrck_rise_s, lrck_fall_s;
   logic in_slot_s, right_s, slot_end_s, left_entry_s, slot_full_s;

   assign soft_rst_s  = ~rstn_sync_q[SYNC_STAGES-1];
   assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
   assign lrck_s      = lrck_sync_q[SYNC_STAGES-1];
   assign sdin_s      = sdin_sync_q[SYNC_STAGES-1];
   assign sclk_rise_s = sclk_s & ~sclk_hist_q;
   assign sclk_fall_s = ~sclk_s & sclk_hist_q;
   assign lrck_rise_s = lrck_s & ~lrck_hist_q;
   assign lrck_fall_s = ~lrck_s & lrck_hist_q;

   assign in_slot_s    = (state_q == ST_LEFT) || (state_q == ST_RIGHT);
   assign right_s      = (state_q == ST_RIGHT);
   assign slot_end_s   = ((state_q == ST_LEFT) && lrck_rise_s) ||
                         ((state_q == ST_RIGHT) && lrck_fall_s);
   assign left_entry_s = (state_q != ST_LEFT) && lrck_fall_s;
   // A rise coinciding with the LRCLK edge still completes the old slot.
   assign slot_full_s  = (cnt_q == CNT_FULL) || (sclk_rise_s && (cnt_q == CNT_LAST));

   // RSTn synchronizer: only the system reset clears it so it can track RSTn.
   always_ff @(posedge clk) begin
      if (rst) begin
         rstn_sync_q <= '0;
      end else begin
         rstn_sync_q <= {rstn_sync_q[SYNC_STAGES-2:0], RSTn};
      end
   end

   // Link input synchronizers and edge-detect history flops.
   always_ff @(posedge clk) begin
      if (rst || soft_rst_s) begin
         sclk_sync_q <= '0;
         lrck_sync_q <= '0;
         sdin_sync_q <= '0;
         sclk_hist_q <= 1'b0;
         lrck_hist_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
         lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], LRCLK};
         sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], SDin};
         sclk_hist_q <= sclk_s;
         lrck_hist_q <= lrck_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst || soft_rst_s) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: partial frames after reset are skipped until an LRCLK fall.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = lrck_fall_s ? ST_LEFT  : ST_IDLE;
         ST_LEFT:  state_d = lrck_rise_s ? ST_RIGHT : ST_LEFT;
         ST_RIGHT: state_d = lrck_fall_s ? ST_LEFT  : ST_RIGHT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs and datapath next-state.
   always_comb begin
      cnt_d     = cnt_q;
      fcnt_d    = fcnt_q;
      lsr_d     = lsr_q;
      rsr_d     = rsr_q;
      lsh_d     = lsh_q;
      rsh_d     = rsh_q;
      lok_d     = lok_q;
      sdout_d   = sdout_q;
      tx_ack_d  = 1'b0;
      rx_vld_d  = 1'b0;
      frm_err_d = 1'b0;
      lft_rx_d  = lft_rx_q;
      rht_rx_d  = rht_rx_q;

      // Receive: rise #1 is the delay slot, rises #2..#DATA_W+1 carry MSB..LSB.
      if (in_slot_s && sclk_rise_s) begin
         if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + CW'(1);
         end else begin
            cnt_d = cnt_q;
         end
         if ((cnt_q != '0) && (cnt_q != CNT_FULL)) begin
            if (right_s) begin
               rsr_d = {rsr_q[DATA_W-2:0], sdin_s};
            end else begin
               lsr_d = {lsr_q[DATA_W-2:0], sdin_s};
            end
         end else begin
            rsr_d = rsr_q;
         end
         // Last right bit closes the frame; publish only if the left slot was whole.
         if (right_s && lok_q && (cnt_q == CNT_LAST)) begin
            lft_rx_d = lsr_q;
            rht_rx_d = {rsr_q[DATA_W-2:0], sdin_s};
            rx_vld_d = 1'b1;
         end else begin
            rx_vld_d = 1'b0;
         end
      end else begin
         cnt_d = cnt_q;
      end

      // Transmit: falls #1..#DATA_W shift the shadow out, later falls drive 0.
      if (in_slot_s && sclk_fall_s) begin
         if (fcnt_q < CNT_LAST) begin
            if (right_s) begin
               sdout_d = rsh_q[DATA_W-1];
               rsh_d   = {rsh_q[DATA_W-2:0], 1'b0};
            end else begin
               sdout_d = lsh_q[DATA_W-1];
               lsh_d   = {lsh_q[DATA_W-2:0], 1'b0};
            end
            fcnt_d = fcnt_q + CW'(1);
         end else begin
            sdout_d = 1'b0;
            fcnt_d  = CNT_FULL;
         end
      end else begin
         sdout_d = sdout_q;
      end

      // Slot boundary: edges seen in this clk above belong to the old slot.
      if (slot_end_s) begin
         frm_err_d = ~slot_full_s;
         if (state_q == ST_LEFT) begin
            lok_d = slot_full_s;
         end else begin
            lok_d = lok_q;
         end
         cnt_d  = '0;
         fcnt_d = '0;
      end else begin
         frm_err_d = 1'b0;
      end

      // Left-slot entry latches both transmit words for the whole frame.
      if (left_entry_s) begin
         lsh_d    = lft_tx;
         rsh_d    = rht_tx;
         tx_ack_d = 1'b1;
         lok_d    = 1'b0;
         cnt_d    = '0;
         fcnt_d   = '0;
      end else begin
         tx_ack_d = 1'b0;
      end
   end

   // Datapath registers; RSTn leaves the last received words intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         fcnt_q    <= '0;
         lsr_q     <= '0;
         rsr_q     <= '0;
         lsh_q     <= '0;
         rsh_q     <= '0;
         lok_q     <= 1'b0;
         sdout_q   <= 1'b0;
         tx_ack_q  <= 1'b0;
         rx_vld_q  <= 1'b0;
         frm_err_q <= 1'b0;
         lft_rx_q  <= '0;
         rht_rx_q  <= '0;
      end else if (soft_rst_s) begin
         cnt_q     <= '0;
         fcnt_q    <= '0;
         lsr_q     <= '0;
         rsr_q     <= '0;
         lsh_q     <= '0;
         rsh_q     <= '0;
         lok_q     <= 1'b0;
         sdout_q   <= 1'b0;
         tx_ack_q  <= 1'b0;
         rx_vld_q  <= 1'b0;
         frm_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         fcnt_q    <= fcnt_d;
         lsr_q     <= lsr_d;
         rsr_q     <= rsr_d;
         lsh_q     <= lsh_d;
         rsh_q     <= rsh_d;
         lok_q     <= lok_d;
         sdout_q   <= sdout_d;
         tx_ack_q  <= tx_ack_d;
         rx_vld_q  <= rx_vld_d;
         frm_err_q <= frm_err_d;
         lft_rx_q  <= lft_rx_d;
         rht_rx_q  <= rht_rx_d;
      end
   end

   assign SDout   = sdout_q;
   assign tx_ack  = tx_ack_q;
   assign rx_vld  = rx_vld_q;
   assign frm_err = frm_err_q;
   assign lft_rx  = lft_rx_q;
   assign rht_rx  = rht_rx_q;

endmodule

// File: tb/tb_codec_model.sv
// tb_codec_model
//   Acts as the I2S link master (SCLK = clk/16, 32 SCLK periods per slot) for
//   codec_model. Expected received frames and expected recovered SDout words are
//   queued when stimulus is issued; monitor processes pop and compare them when
//   the DUT pulses rx_vld or the master finishes recovering a word.
module tb_codec_model;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          RSTn = 1'b1;
   logic          SCLK = 1'b0;
   logic          LRCLK = 1'b0;
   logic          SDin = 1'b0;
   logic          SDout;
   logic [DW-1:0] lft_tx = 16'h0000;
   logic [DW-1:0] rht_tx = 16'h0000;
   logic          tx_ack;
   logic [DW-1:0] lft_rx;
   logic [DW-1:0] rht_rx;
   logic          rx_vld;
   logic          frm_err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_ack    = 0;
   int n_vld    = 0;
   int n_err    = 0;
   int a0, v0, e0;
   logic prev_ack = 1'b0, prev_vld = 1'b0, prev_err = 1'b0;

   logic [31:0]   rx_exp_q[$];
   logic [DW-1:0] tx_exp_q[$];
   logic [DW-1:0] mst_word = 16'h0000;
   logic          mst_vld  = 1'b0;
   logic [DW-1:0] rec_w;
   int            nz_w;

   codec_model #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .RSTn(RSTn), .SCLK(SCLK), .LRCLK(LRCLK), .SDin(SDin),
      .SDout(SDout), .lft_tx(lft_tx), .rht_tx(rht_tx), .tx_ack(tx_ack),
      .lft_rx(lft_rx), .rht_rx(rht_rx), .rx_vld(rx_vld), .frm_err(frm_err)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One slot: LRCLK and SDin change with SCLK fall; SDout sampled at SCLK rise.
   task automatic send_slot(input logic lr, input logic [DW-1:0] word, input int nper,
                            input logic chg, input logic [DW-1:0] chg_val,
                            output logic [DW-1:0] rec, output int nz);
      rec = 16'h0000;
      nz  = 0;
      for (int p = 0; p < nper; p++) begin
         @(negedge clk);
         SCLK  = 1'b0;
         LRCLK = lr;
         SDin  = (p >= 1 && p <= DW) ? word[DW-p] : 1'b0;
         if (chg && p == 8) lft_tx = chg_val;
         repeat (8) @(negedge clk);
         if (p >= 1 && p <= DW) rec[DW-p] = SDout;
         else if (SDout !== 1'b0) nz++;
         SCLK = 1'b1;
         repeat (7) @(negedge clk);
      end
   endtask

   task automatic publish(input logic [DW-1:0] w);
      mst_word = w;
      mst_vld  = 1'b1;
      @(negedge clk);
      mst_vld  = 1'b0;
   endtask

   task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nr,
                             input logic exp_rx, input logic chg, input logic [DW-1:0] chg_val,
                             input logic [DW-1:0] exp_tl, input logic [DW-1:0] exp_tr,
                             input logic chk_tr, input logic chk_zero);
      logic [DW-1:0] rec;
      int nz;
      if (exp_rx) rx_exp_q.push_back({l, r});
      tx_exp_q.push_back(exp_tl);
      send_slot(1'b0, l, 32, chg, chg_val, rec, nz);
      publish(rec);
      if (chk_zero) check("sdout_zero_left", 32'(nz), 32'd0);
      send_slot(1'b1, r, nr, 1'b0, 16'h0000, rec, nz);
      if (chk_tr) begin
         tx_exp_q.push_back(exp_tr);
         publish(rec);
      end
      if (chk_zero) check("sdout_zero_right", 32'(nz), 32'd0);
   endtask

   // Pulse monitor and receive scoreboard.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (tx_ack === 1'b1) begin
            n_ack++;
            check("tx_ack_width", {31'd0, prev_ack}, 32'd0);
         end
         if (frm_err === 1'b1) begin
            n_err++;
            check("frm_err_width", {31'd0, prev_err}, 32'd0);
         end
         if (rx_vld === 1'b1) begin
            n_vld++;
            check("rx_vld_width", {31'd0, prev_vld}, 32'd0);
            if (rx_exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL rx_unexpected: got %h expected no rx_vld", {lft_rx, rht_rx});
            end else begin
               e = rx_exp_q.pop_front();
               check("rx_words", {lft_rx, rht_rx}, e);
            end
         end
         prev_ack = tx_ack;
         prev_vld = rx_vld;
         prev_err = frm_err;
      end
   end

   // Transmit scoreboard: words recovered by the master from SDout.
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(posedge clk);
         if (mst_vld) begin
            if (tx_exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL tx_unexpected: got %h expected no word", mst_word);
            end else begin
               e = tx_exp_q.pop_front();
               check("tx_word", {16'd0, mst_word}, {16'd0, e});
            end
         end
      end
   end

   initial begin
      // Reset state.
      repeat (5) @(negedge clk);
      check("rst_sdout",   {31'd0, SDout},   32'd0);
      check("rst_tx_ack",  {31'd0, tx_ack},  32'd0);
      check("rst_rx_vld",  {31'd0, rx_vld},  32'd0);
      check("rst_frm_err", {31'd0, frm_err}, 32'd0);
      check("rst_rx",      {lft_rx, rht_rx}, 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("idle_sdout", {31'd0, SDout}, 32'd0);
      check("idle_pulses", 32'(n_ack + n_vld + n_err), 32'd0);

      // LRCLK rise only (no fall yet): nothing must happen.
      lft_tx = 16'h8001;
      rht_tx = 16'h7FFE;
      send_slot(1'b1, 16'hFFFF, 32, 1'b0, 16'h0000, rec_w, nz_w);
      check("nofall_sdout", {16'd0, rec_w}, 32'd0);
      check("nofall_sdout_tail", 32'(nz_w), 32'd0);
      check("nofall_pulses", 32'(n_ack + n_vld + n_err), 32'd0);

      // Two full frames.
      send_frame(16'hA5C3, 16'h0F0F, 32, 1'b1, 1'b0, 16'h0000, 16'h8001, 16'h7FFE, 1'b1, 1'b1);
      check("f1_ack_cnt", 32'(n_ack), 32'd1);
      check("f1_vld_cnt", 32'(n_vld), 32'd1);
      send_frame(16'hA5C3, 16'h0F0F, 32, 1'b1, 1'b0, 16'h0000, 16'h8001, 16'h7FFE, 1'b1, 1'b1);
      check("f2_ack_cnt", 32'(n_ack), 32'd2);
      check("f2_vld_cnt", 32'(n_vld), 32'd2);
      check("f2_err_cnt", 32'(n_err), 32'd0);

      // Mid-left-slot tx change applies to the next frame only.
      lft_tx = 16'h1234;
      send_frame(16'h1357, 16'h2468, 32, 1'b1, 1'b1, 16'h5678, 16'h1234, 16'h7FFE, 1'b1, 1'b1);
      send_frame(16'h1111, 16'h2222, 10, 1'b0, 1'b0, 16'h0000, 16'h5678, 16'h7FFE, 1'b0, 1'b1);
      check("short_vld_cnt", 32'(n_vld), 32'd3);
      check("short_rx_hold", {lft_rx, rht_rx}, 32'h1357_2468);
      send_frame(16'hCAFE, 16'hBEEF, 32, 1'b1, 1'b0, 16'h0000, 16'h5678, 16'h7FFE, 1'b1, 1'b0);
      check("short_err_cnt", 32'(n_err), 32'd1);
      check("recover_vld_cnt", 32'(n_vld), 32'd4);

      // RSTn low mid-right-slot: received words kept.
      tx_exp_q.push_back(16'h5678);
      send_slot(1'b0, 16'h1111, 32, 1'b0, 16'h0000, rec_w, nz_w);
      publish(rec_w);
      send_slot(1'b1, 16'h2222, 8, 1'b0, 16'h0000, rec_w, nz_w);
      RSTn = 1'b0;
      repeat (10) @(negedge clk);
      check("rstn_sdout", {31'd0, SDout}, 32'd0);
      check("rstn_rx_kept", {lft_rx, rht_rx}, 32'hCAFE_BEEF);
      RSTn = 1'b1;
      repeat (10) @(negedge clk);
      a0 = n_ack; v0 = n_vld; e0 = n_err;
      send_slot(1'b1, 16'hFFFF, 24, 1'b0, 16'h0000, rec_w, nz_w);
      check("rstn_idle_sdout", {16'd0, rec_w}, 32'd0);
      check("rstn_idle_pulses", 32'(n_ack - a0 + n_vld - v0 + n_err - e0), 32'd0);
      send_frame(16'h0001, 16'h8000, 32, 1'b1, 1'b0, 16'h0000, 16'h5678, 16'h7FFE, 1'b1, 1'b1);
      check("rstn_resume_ack", 32'(n_ack - a0), 32'd1);

      // rst high mid-right-slot: received words cleared.
      tx_exp_q.push_back(16'h5678);
      send_slot(1'b0, 16'h3333, 32, 1'b0, 16'h0000, rec_w, nz_w);
      publish(rec_w);
      send_slot(1'b1, 16'h4444, 8, 1'b0, 16'h0000, rec_w, nz_w);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_mid_sdout", {31'd0, SDout}, 32'd0);
      check("rst_mid_rx_clr", {lft_rx, rht_rx}, 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      a0 = n_ack; v0 = n_vld; e0 = n_err;
      send_slot(1'b1, 16'hFFFF, 24, 1'b0, 16'h0000, rec_w, nz_w);
      check("rst_idle_sdout", {16'd0, rec_w}, 32'd0);
      check("rst_idle_pulses", 32'(n_ack - a0 + n_vld - v0 + n_err - e0), 32'd0);
      send_frame(16'h5A5A, 16'hA5A5, 32, 1'b1, 1'b0, 16'h0000, 16'h5678, 16'h7FFE, 1'b1, 1'b1);
      check("rst_resume_vld", 32'(n_vld - v0), 32'd1);

      repeat (20) @(negedge clk);
      check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
      check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
      check("total_err_cnt", 32'(n_err), 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
